// File: rtl/prog_sequencer_pkg.sv
// rtl/prog_sequencer_pkg.sv - shared states and program table for the run sequencer
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RST_CORE,
    RUN,
    DONE,
    TIMEOUT
  } seq_state_t;

  localparam logic [11:0] PROG_START [3] = '{12'h000, 12'h100, 12'h200};
  localparam logic [1:0]  PROG_ILLEGAL   = 2'd3;

  // Illegal index falls back to program 0; the sequencer never latches it anyway.
  function automatic logic [11:0] prog_start_addr(input logic [1:0] sel);
    case (sel)
      2'd1:    return PROG_START[1];
      2'd2:    return PROG_START[2];
      default: return PROG_START[0];
    endcase
  endfunction

endpackage

// File: rtl/prog_sequencer_if.sv
// rtl/prog_sequencer_if.sv - host/core handshake bundle for the run sequencer
interface prog_sequencer_if #(
  parameter int D  = 12,
  parameter int CW = 13
);
  logic          start;
  logic [1:0]    prog_sel;
  logic          core_done;
  logic          core_reset;
  logic [D-1:0]  start_addr;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          err;
  logic [CW-1:0] cycle_count;

  modport master (
    output start, prog_sel, core_done,
    input  core_reset, start_addr, busy, done, timeout, err, cycle_count
  );

  modport slave (
    input  start, prog_sel, core_done,
    output core_reset, start_addr, busy, done, timeout, err, cycle_count
  );
endinterface

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - holds the core in reset, launches it, and times the run
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int D       = 12,
  parameter int RST_CYC = 2,
  parameter int MAX_CYC = 4096,
  parameter int CW      = $clog2(MAX_CYC + 1)
) (
  input  logic           clk,
  input  logic           reset,
  prog_sequencer_if.slave bus
);

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  seq_state_t    state;
  logic [RW-1:0] rst_cnt;
  logic [1:0]    prog_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_inc;
  logic          core_reset_q;
  logic          busy_q;
  logic          done_q;
  logic          timeout_q;
  logic          err_q;

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      rst_cnt      <= '0;
      prog_q       <= '0;
      cnt_q        <= '0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.prog_sel == PROG_ILLEGAL) begin
              err_q <= 1'b1;
            end else begin
              prog_q  <= bus.prog_sel;
              rst_cnt <= '0;
              busy_q  <= 1'b1;
              state   <= RST_CORE;
            end
          end
        end
        RST_CORE: begin
          if (rst_cnt == RW'(RST_CYC - 1)) begin
            cnt_q        <= '0;
            core_reset_q <= 1'b0;
            state        <= RUN;
          end else begin
            rst_cnt <= rst_cnt + RW'(1);
          end
        end
        RUN: begin
          cnt_q <= cnt_inc;
          // core_done is checked first so a done on the final watchdog cycle is a clean finish.
          if (bus.core_done) begin
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            state        <= DONE;
          end else if (cnt_inc == CW'(MAX_CYC)) begin
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            timeout_q    <= 1'b1;
            state        <= TIMEOUT;
          end
        end
        DONE, TIMEOUT: begin
          if (!bus.start) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.core_reset  = core_reset_q;
  assign bus.start_addr  = D'(prog_start_addr(prog_q));
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout     = timeout_q;
  assign bus.err         = err_q;
  assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - table-driven scoreboard bench for prog_sequencer
module tb_prog_sequencer;

  localparam int D       = 12;
  localparam int RST_CYC = 2;
  localparam int MAX_CYC = 8;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef struct {
    logic [1:0] sel;
    int         done_at;   // RUN edge carrying core_done; 0 means never
    logic [11:0] exp_addr;
    int         exp_cnt;
    logic       exp_to;
  } vec_t;

  typedef struct {
    logic [11:0] addr;
    int          cnt;
    logic        to;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  exp_t sb[$];
  vec_t vecs[6];

  prog_sequencer_if #(.D(D), .CW(CW)) bus ();

  prog_sequencer #(
    .D(D), .RST_CYC(RST_CYC), .MAX_CYC(MAX_CYC), .CW(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Launches one run, drives core_done at RUN edge done_at, and scores the finish.
  task automatic run_vec(input vec_t v);
    exp_t e;
    exp_t got;
    int   rst_hi;
    int   k;
    bus.start    = 1'b1;
    bus.prog_sel = v.sel;
    e.addr = v.exp_addr;
    e.cnt  = v.exp_cnt;
    e.to   = v.exp_to;
    sb.push_back(e);
    @(negedge clk);
    chk("launch_busy", {31'd0, bus.busy}, 32'd1);
    rst_hi = 0;
    while (bus.core_reset && bus.busy && rst_hi < 10) begin
      rst_hi++;
      @(negedge clk);
    end
    chk("core_reset_cycles", rst_hi, RST_CYC);
    chk("run_cnt_start", {28'd0, bus.cycle_count}, 32'd0);
    k = 0;
    while (!bus.done && k < MAX_CYC + 4) begin
      k++;
      bus.core_done = (k == v.done_at);
      @(negedge clk);
    end
    bus.core_done = 1'b0;
    if (!bus.done) chk("run_bound", 32'd0, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      chk("start_addr", {20'd0, bus.start_addr}, {20'd0, got.addr});
      chk("cycle_count", {28'd0, bus.cycle_count}, got.cnt);
      chk("timeout", {31'd0, bus.timeout}, {31'd0, got.to});
      chk("done_busy", {31'd0, bus.busy}, 32'd0);
      chk("done_core_reset", {31'd0, bus.core_reset}, 32'd1);
    end
    @(negedge clk);
    chk("done_hold", {31'd0, bus.done}, 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    chk("done_fall", {30'd0, bus.done, bus.timeout}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{sel: 2'd1, done_at: 5, exp_addr: 12'h100, exp_cnt: 5, exp_to: 1'b0};
    vecs[1] = '{sel: 2'd0, done_at: 1, exp_addr: 12'h000, exp_cnt: 1, exp_to: 1'b0};
    vecs[2] = '{sel: 2'd2, done_at: 0, exp_addr: 12'h200, exp_cnt: 8, exp_to: 1'b1};
    vecs[3] = '{sel: 2'd1, done_at: 8, exp_addr: 12'h100, exp_cnt: 8, exp_to: 1'b0};
    vecs[4] = '{sel: 2'd0, done_at: 7, exp_addr: 12'h000, exp_cnt: 7, exp_to: 1'b0};
    vecs[5] = '{sel: 2'd2, done_at: 3, exp_addr: 12'h200, exp_cnt: 3, exp_to: 1'b0};

    reset         = 1'b0;
    bus.start     = 1'b1;
    bus.prog_sel  = 2'd1;
    bus.core_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_core_reset", {31'd0, bus.core_reset}, 32'd1);
    chk("rst_outputs", {bus.busy, bus.done, bus.timeout, bus.err}, 32'd0);
    chk("rst_cycle_count", {28'd0, bus.cycle_count}, 32'd0);
    chk("rst_start_addr", {20'd0, bus.start_addr}, 32'd0);

    reset = 1'b1;
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Illegal program held for two sampled cycles pulses err each time.
    bus.start    = 1'b1;
    bus.prog_sel = 2'd3;
    @(negedge clk);
    chk("err_pulse", {31'd0, bus.err}, 32'd1);
    chk("err_busy", {31'd0, bus.busy}, 32'd0);
    chk("err_addr_kept", {20'd0, bus.start_addr}, 32'h000);
    @(negedge clk);
    chk("err_repeat", {31'd0, bus.err}, 32'd1);
    bus.start = 1'b0;
    @(negedge clk);
    chk("err_clear", {31'd0, bus.err}, 32'd0);

    // Mid-run reset, then relaunch on program 2.
    bus.start    = 1'b1;
    bus.prog_sel = 2'd1;
    for (int i = 0; i < RST_CYC + 3; i++) @(negedge clk);
    chk("mid_cnt", {28'd0, bus.cycle_count}, 32'd2);
    @(posedge clk);
    #2;
    reset     = 1'b0;
    bus.start = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_core_reset", {31'd0, bus.core_reset}, 32'd1);
    chk("mid_rst_cnt", {28'd0, bus.cycle_count}, 32'd0);
    chk("mid_rst_addr", {20'd0, bus.start_addr}, 32'd0);
    chk("mid_rst_done", {bus.done, bus.timeout}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_vec(vecs[5]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run controller for the single-cycle core: accepts a start request and program select from the bench or host, holds the core in reset while the PC start address is presented, releases it, and counts execution cycles. It finishes on the core's done flag or on a watchdog timeout. It sits above the core top level and owns the core's reset and the PC start address.

## Interface
- `D`, 12: PC / start-address width.
- `RST_CYC`, 2: cycles the core is held in reset before each run (≥1).
- `MAX_CYC`, 4096: watchdog limit in RUN cycles (≥2).
- `CW`, $clog2(MAX_CYC+1): cycle-counter width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; low forces every register to its reset value immediately.
- `start`  in  1  level run request; sampled only in IDLE.
- `prog_sel`  in  2  program index; 0–2 legal, 3 illegal.
- `core_done`  in  1  done flag from the core; sampled only in RUN.
- `core_reset`  out  1  active-high reset to the core.
- `start_addr`  out  D  PC start address for the latched program.
- `busy`  out  1  high in RST_CORE and RUN.
- `done`  out  1  run finished, either normally or by timeout.
- `timeout`  out  1  run ended by the watchdog.
- `err`  out  1  one-cycle pulse on an illegal `prog_sel` start.
- `cycle_count`  out  CW  RUN cycles of the current or last run.

## Operation
- All outputs are registered; they are Moore decodes of the state register or of dedicated registers.
- Reset values: state=IDLE, `core_reset`=1, `busy`=0, `done`=0, `timeout`=0, `err`=0, `cycle_count`=0, `start_addr`=0, latched program=0.
- **IDLE**: `core_reset`=1.
  - If `start`=1 and `prog_sel`<3: latch `prog_sel`, load `start_addr` from PROG_START[prog_sel], clear the reset counter, go to RST_CORE.
  - If `start`=1 and `prog_sel`=3: pulse `err` for one cycle and stay in IDLE. `err` pulses again on every sampled cycle while this condition persists.
- **RST_CORE**: `core_reset`=1, `busy`=1. Stay for exactly RST_CYC cycles, then go to RUN and clear `cycle_count` to 0.
- **RUN**: `core_reset`=0, `busy`=1. `cycle_count` increments on every RUN cycle, including the cycle in which `core_done` is sampled.
  - If `core_done`=1: go to DONE.
  - Otherwise, if the incremented count equals MAX_CYC: go to TIMEOUT.
  - If both occur on the same cycle, `core_done` wins and the next state is DONE.
- **DONE**: `done`=1, `core_reset`=1, `busy`=0, `cycle_count` frozen. Go to IDLE when `start`=0.
- **TIMEOUT**: same as DONE, plus `timeout`=1. `cycle_count` freezes at MAX_CYC.
- A new run therefore requires `start` to go low and then high again. Holding `start` high keeps the block in DONE or TIMEOUT.
- Changes to `start` and `prog_sel` outside IDLE are ignored. `start_addr` holds its value until the next legal launch.
- Reset asserted mid-run returns the block to IDLE with reset values immediately; no completion is reported.
- `cycle_count` never wraps; MAX_CYC is its maximum reachable value.

## Timing
- Launch: `start` is sampled high at edge 0.
  - State is RST_CORE after edge 0; `start_addr` is valid from that point.
  - `core_reset` stays high through edge RST_CYC.
  - State is RUN after edge RST_CYC, so `core_reset` drops in cycle RST_CYC+1.
- Completion: `core_done` is sampled at RUN edge k (k≥1). After that edge, `done`=1 and `cycle_count`=k.
- Timeout: with no `core_done`, `timeout` and `done` rise after RUN edge MAX_CYC, with `cycle_count`=MAX_CYC.
- `err` is high for exactly the cycle after the illegal sample.
- `done`/`timeout` fall one cycle after `start` is sampled low.

## Structure
- Package `seq_pkg` holds:
  - state enum `seq_state_t` {IDLE, RST_CORE, RUN, DONE, TIMEOUT};
  - `PROG_START[3]` = {12'h000, 12'h100, 12'h200};
  - `PROG_ILLEGAL` = 2'd3.
- Single module with no sub-modules. The reset counter and cycle counter are inline registers.

## Test plan
- Reset defaults: drive `reset`=0 with `start`=1 → `core_reset`=1, all other outputs 0. Release `reset` → IDLE, then launch on the next edge.
- Normal run: `prog_sel`=1, `start`=1, `core_done` rises on the 5th RUN cycle → `start_addr`=12'h100, `core_reset` high for 2 cycles, `done`=1, `cycle_count`=5, `timeout`=0.
- Timeout: MAX_CYC=8, `core_done` held 0 → `timeout`=1, `done`=1, `cycle_count`=8.
- Collision: MAX_CYC=8, `core_done`=1 on RUN cycle 8 → DONE with `timeout`=0 and `cycle_count`=8.
- Illegal program: `prog_sel`=3, `start`=1 for one cycle → `err` high for 1 cycle, `busy`=0, `start_addr` unchanged.
- Mid-run reset and relaunch: pull `reset` low in RUN cycle 3 → immediate IDLE values. Then `start` with `prog_sel`=2 → `start_addr`=12'h200 and a fresh `cycle_count` starting from 0.
